// File: rtl/cordic_input_stage.sv
// CORDIC rotation-mode input stage: folds the angle into +/-90 deg, loads the initial vector
// and carries valid/negate tags plus an in-flight count. Build macro: CORDIC_GAIN_COMP_EN.
module cordic_input_stage #(
   parameter int          STAGES    = 16,
   parameter logic [31:0] GAIN_INIT = 32'h26DD3B6A
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [31:0] angle_in,
   input  logic        flush,
   output logic [31:0] x_out,
   output logic [31:0] y_out,
   output logic [31:0] z_out,
   output logic        out_valid,
   output logic        out_negate,
   output logic        tag_valid,
   output logic        tag_negate,
   output logic        busy
);
   localparam int CW = $clog2(STAGES + 2);

`ifdef CORDIC_GAIN_COMP_EN
   localparam bit GAIN_COMP_C = 1'b1;
`else
   localparam bit GAIN_COMP_C = 1'b0;
`endif
   localparam logic [31:0] X_INIT = GAIN_COMP_C ? GAIN_INIT : 32'h4000_0000;

   // Returns {negate, z}; angles outside [-90,+90) deg sit where bits 31 and 30 differ
   function automatic logic [32:0] fold_angle(input logic [31:0] a);
      logic neg;
      neg = a[31] ^ a[30];
      return neg ? {1'b1, ~a[31], a[30:0]} : {1'b0, a};
   endfunction

   logic [32:0]       fold_s;
   logic              accept_s;
   logic [31:0]       x_r, y_r, z_r;
   logic              out_valid_r, out_negate_r;
   logic [STAGES-1:0] dv_r, dn_r;
   logic [CW-1:0]     count_r, count_next_s;
   logic              busy_r;

   assign fold_s   = fold_angle(angle_in);
   assign accept_s = in_valid & ~flush;

   // Next in-flight count: one in per accepted sample, one out per emitted tag
   always_comb begin
      count_next_s = count_r;
      if (flush) begin
         count_next_s = {CW{1'b0}};
      end else begin
         case ({in_valid, dv_r[STAGES-1]})
            2'b10:   count_next_s = count_r + CW'(1);
            2'b01:   count_next_s = count_r - CW'(1);
            default: count_next_s = count_r;
         endcase
      end
   end

   // Initial vector registers; they hold between samples and across flush
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_r          <= 32'h0000_0000;
         y_r          <= 32'h0000_0000;
         z_r          <= 32'h0000_0000;
         out_negate_r <= 1'b0;
      end else if (accept_s) begin
         x_r          <= X_INIT;
         y_r          <= 32'h0000_0000;
         z_r          <= fold_s[31:0];
         out_negate_r <= fold_s[32];
      end else begin
         x_r          <= x_r;
         y_r          <= y_r;
         z_r          <= z_r;
         out_negate_r <= out_negate_r;
      end
   end

   // Valid flags, tag delay line and in-flight count; flush clears only valid state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_r <= 1'b0;
         dv_r        <= {STAGES{1'b0}};
         dn_r        <= {STAGES{1'b0}};
         count_r     <= {CW{1'b0}};
         busy_r      <= 1'b0;
      end else begin
         out_valid_r <= accept_s;
         dn_r[0]     <= out_negate_r;
         for (int k = STAGES - 1; k >= 1; k--) begin
            dn_r[k] <= dn_r[k-1];
         end
         if (flush) begin
            dv_r <= {STAGES{1'b0}};
         end else begin
            dv_r[0] <= out_valid_r;
            for (int k = STAGES - 1; k >= 1; k--) begin
               dv_r[k] <= dv_r[k-1];
            end
         end
         count_r <= count_next_s;
         busy_r  <= (count_next_s != {CW{1'b0}});
      end
   end

   assign x_out      = x_r;
   assign y_out      = y_r;
   assign z_out      = z_r;
   assign out_valid  = out_valid_r;
   assign out_negate = out_negate_r;
   assign tag_valid  = dv_r[STAGES-1];
   assign tag_negate = dn_r[STAGES-1];
   assign busy       = busy_r;
endmodule

// File: doc/cordic_input_stage.md
# cordic_input_stage

Head of the rotation-mode CORDIC pipeline. Accepts a binary-angle sample, folds it into the ±90° convergence range, and registers the initial (x, y, z) vector for the first shift-accumulate stage. Runs a valid/negate tag delay line alongside the data-only shift-accumulate chain, so the output stage receives a sample-valid flag and a quadrant-correction flag aligned with the last stage's result. Also counts samples in flight for drain detection.

## Interface
- STAGES, 16, number of shift-accumulate stages downstream (1..64); sets tag delay depth
- GAIN_INIT, 32'h26DD3B6A, initial x when gain compensation is compiled in (1/K = 0.6072529 in Q2.30)
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  angle_in is valid this cycle; always accepted, no backpressure
- angle_in  in  32  signed binary angle, 2^31 = 180° (0x40000000 = 90°)
- flush  in  1  synchronous clear of all valid state
- x_out  out  32  initial x to stage 0 (Q2.30)
- y_out  out  32  initial y to stage 0
- z_out  out  32  folded residual angle to stage 0, same binary-angle units as stage tan constants
- out_valid  out  1  x/y/z_out hold a new sample
- out_negate  out  1  sample was folded by 180°
- tag_valid  out  1  out_valid delayed by STAGES cycles
- tag_negate  out  1  out_negate delayed by STAGES cycles
- busy  out  1  in-flight count nonzero

## Operation
- Fold, per sample: if signed angle_in >= 0x40000000 or < 0xC0000000, then z = angle_in + 0x80000000 (mod 2^32) and negate = 1; otherwise z = angle_in and negate = 0. Folded z always lies in [0xC0000000, 0x40000000).
- Boundaries: 0x40000000 folds to 0xC0000000 with negate = 1. 0x80000000 folds to 0x00000000 with negate = 1. 0xC0000000 passes unchanged with negate = 0.
- Load when in_valid = 1: x_out = initial x (see Configuration), y_out = 0, z_out = folded z, out_valid = 1, out_negate = negate.
- When in_valid = 0: x/y/z_out and out_negate hold; out_valid = 0.
- Delay line: registers d[1..STAGES] of {valid, negate}. d[1] <= {out_valid, out_negate}, d[k] <= d[k-1]. tag_valid and tag_negate = d[STAGES].
- The output stage negates final x and y when tag_negate = 1.
- In-flight count covers all set valid bits across out_valid and d[1..STAGES]. Width is clog2(STAGES+2). Each edge: count += in_valid, count -= tag_valid. Simultaneous increment and decrement leaves it unchanged. Maximum value is STAGES+1; it never wraps.
- busy = (count != 0), registered-state derived.
- flush has priority. At the edge it clears out_valid, all d[k] valid bits, and count to 0. Data registers and negate bits are untouched. An in_valid coinciding with flush is dropped.

## Timing
- Reset (asynchronous): x_out, y_out, z_out = 0. out_valid, out_negate, tag_valid, tag_negate = 0. All d[k] = 0. count = 0, busy = 0.
- angle_in to x/y/z_out and out_valid: 1 edge.
- out_valid to tag_valid: STAGES edges, matching the one-register-per-stage shift-accumulate chain.
- Total angle_in to tag_valid: STAGES+1 edges.
- Throughput: one sample per clock, with continuous back-to-back in_valid.
- Reset deasserted mid-stream: the first sample accepted after release appears on tag_valid STAGES+1 edges later; no stale tags are emitted.

## Configuration
- CORDIC_GAIN_COMP_EN defined: initial x = GAIN_INIT. The final vector is unit magnitude: x = cos, y = sin.
- CORDIC_GAIN_COMP_EN undefined: initial x = 32'h40000000 (1.0). The final vector carries CORDIC gain K ≈ 1.6468, and the output stage compensates.
- Fold, tags and count are identical in both builds.

## Test plan
- Reset, then single angle 0x20000000 (45°) -> next edge: z_out = 0x20000000, y_out = 0, out_negate = 0, x_out = 0x26DD3B6A (macro on) or 0x40000000 (macro off). tag_valid pulses exactly STAGES = 16 edges after out_valid; busy high for 17 cycles.
- Angles 0x60000000, 0x40000000, 0x80000000, 0xC0000000 back-to-back -> z_out = 0xE0000000, 0xC0000000, 0x00000000, 0xC0000000. out_negate = 1, 1, 1, 0. Same negate pattern appears on tag_negate 16 edges later.
- Continuous in_valid for 40 cycles -> count saturates at 17 and holds there. tag_valid continuous from edge 17; count falls to 0 exactly 17 edges after in_valid drops.
- flush asserted with 5 samples in flight and in_valid = 1 -> next edge: count = 0, busy = 0, out_valid = 0. No tag_valid is ever emitted for those 6 samples.
- rst_n pulsed low asynchronously between edges with 10 samples in flight -> all outputs 0 immediately. After release, a new sample yields exactly one tag_valid, 17 edges later.
